fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_queue.sv | 77 +++++++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the datapath width, the default fetch-queue depth and the
// fetch-entry type ({pc, instr}) that moves through the fetch queue.
package fetch_stage_pkg;

    localparam int XLEN             = 32;
    localparam int FQ_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: a small FIFO of fetch entries between the instruction
// memory response and the decode stage.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-low reset (empties the queue)
//   clear      synchronous flush (empties the queue)
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        remove the head entry
//   head       entry at the head of the queue
//   full       DEPTH entries held
//   empty      no entries held
//   count      occupancy, 0..DEPTH
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               pop_ok;
    logic               push_ok;

    // Requests that would underflow or overflow are ignored; a push into
    // a full queue is accepted only when a pop frees a slot this cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read unless count says it is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Presents pc_in to a synchronous instruction
// memory, pairs each returned word with the PC that requested it, and
// queues the pair for decode. When the queue has no room the response is
// dropped and the PC is redirected back to the dropped address (replay).
// A downstream flush discards everything in flight and redirects the PC.
//
// Ports
//   clk           clock
//   reset         synchronous active-low reset
//   pc_in         current word-address program counter
//   imem_addr     instruction memory address (equals pc_in)
//   imem_rdata    instruction word, valid the cycle after imem_addr
//   flush         taken branch/jump resolved downstream
//   flush_target  redirect address accompanying flush
//   pc_src        PC redirect strobe
//   pc_set        PC redirect address
//   id_valid      instruction available to decode
//   id_ready      decode accepts the head instruction
//   id_instr      head instruction word
//   id_pc         head instruction address
//   replay_cnt    saturating count of replay redirects
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              FQ_DEPTH = FQ_DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RST_PC   = 32'h0000_0000,
    localparam int             CNT_W    = $clog2(FQ_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_target,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_set,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [15:0]     replay_cnt
);

    logic [XLEN-1:0]    req_pc;
    logic               req_v;
    logic               q_push;
    logic               q_pop;
    logic               q_full;
    logic               q_empty;
    logic [CNT_W-1:0]   q_count;
    logic [ENTRY_W-1:0] q_head;
    fetch_entry_t       push_entry;
    fetch_entry_t       head_entry;
    logic               has_space;
    logic               replay;

    assign imem_addr = pc_in;

    // A flush wins over everything: the pop is ignored, the response is
    // discarded rather than queued, and no replay is counted.
    assign q_pop     = id_ready && !q_empty && !flush;
    assign has_space = !q_full || q_pop;
    assign q_push    = req_v && has_space && !flush;
    assign replay    = req_v && !has_space && !flush;

    assign push_entry.pc    = req_pc;
    assign push_entry.instr = imem_rdata;
    assign head_entry       = q_head;

    // Head fields are forced to zero when nothing is queued so decode
    // never sees stale storage contents.
    assign id_valid = (q_count != '0);
    assign id_instr = id_valid ? head_entry.instr : '0;
    assign id_pc    = id_valid ? head_entry.pc    : '0;

    always_comb begin
        pc_src = 1'b0;
        pc_set = '0;
        if (flush) begin
            pc_src = 1'b1;
            pc_set = flush_target;
        end else if (replay) begin
            pc_src = 1'b1;
            pc_set = req_pc;
        end
    end

    // A request issued in the same cycle as a redirect belongs to the
    // wrong path, so its response next cycle is marked invalid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_pc <= RST_PC;
            req_v  <= 1'b0;
        end else begin
            req_pc <= pc_in;
            req_v  <= !pc_src;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            replay_cnt <= '0;
        end else if (replay && (replay_cnt != 16'hFFFF)) begin
            replay_cnt <= replay_cnt + 16'd1;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The bench plays the PC register and
// a synchronous instruction memory whose word n holds n+100, and logs
// every instruction handed to decode.
module tb_fetch_stage;

    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_target;
    logic        pc_src;
    logic [31:0] pc_set;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [15:0] replay_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_pc[$];
    logic [31:0] log_instr[$];

    fetch_stage #(
        .FQ_DEPTH (FQ_DEPTH),
        .RST_PC   (RST_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .flush_target (flush_target),
        .pc_src       (pc_src),
        .pc_set       (pc_set),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .replay_cnt   (replay_cnt)
    );

    always #5 clk = ~clk;

    // One clock cycle: sample the redirect and handshake mid-cycle, then
    // after the edge advance the PC and return the memory word for the
    // address that was presented.
    task automatic tick();
        logic        src;
        logic [31:0] set;
        logic [31:0] addr;
        logic        rst_now;
        @(negedge clk);
        src     = pc_src;
        set     = pc_set;
        addr    = imem_addr;
        rst_now = reset;
        if (id_valid && id_ready && !flush && reset) begin
            log_pc.push_back(id_pc);
            log_instr.push_back(id_instr);
        end
        @(posedge clk);
        #1;
        if (!rst_now)  pc_in = RST_PC;
        else if (src)  pc_in = set;
        else           pc_in = pc_in + 32'd1;
        imem_rdata = addr + 32'd100;
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b0;
        flush        = 1'b0;
        flush_target = 32'h0;
        id_ready     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        log_pc.delete();
        log_instr.delete();
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        flush        = 1'b0;
        flush_target = 32'h0;
        id_ready     = 1'b1;
        tick();
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid got %0b want 0", id_valid); end
        checks++; if (pc_src !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_src got %0b want 0", pc_src); end
        checks++; if (pc_set !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_set got %0h want 0", pc_set); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_instr got %0h want 0", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_id_pc got %0h want 0", id_pc); end
        checks++; if (replay_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_replay_cnt got %0h want 0", replay_cnt); end
        checks++; if (imem_addr !== RST_PC) begin errors++; $display("[TB] FAIL reset_imem_addr got %0h want %0h", imem_addr, RST_PC); end
    endtask

    task automatic test_stream();
        apply_reset();
        id_ready = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_latency1 got %0b want 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_latency2 got %0b want 1", id_valid); end
        checks++; if (id_pc !== 32'd0) begin errors++; $display("[TB] FAIL stream_first_pc got %0h want 0", id_pc); end
        checks++; if (id_instr !== 32'd100) begin errors++; $display("[TB] FAIL stream_first_instr got %0d want 100", id_instr); end
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_pc.size() <= i) begin
                errors++; $display("[TB] FAIL stream_order[%0d] got none want pc %0d", i, i);
            end else if (log_pc[i] !== 32'(i) || log_instr[i] !== 32'(i + 100)) begin
                errors++; $display("[TB] FAIL stream_order[%0d] got pc %0d instr %0d want pc %0d instr %0d", i, log_pc[i], log_instr[i], i, i + 100);
            end
        end
        checks++; if (replay_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stream_replay_cnt got %0d want 0", replay_cnt); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        id_ready = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin errors++; $display("[TB] FAIL bp_head got v %0b pc %0d want v 1 pc 0", id_valid, id_pc); end
        checks++; if (pc_src !== 1'b1 || pc_set !== 32'd2) begin errors++; $display("[TB] FAIL bp_replay got src %0b set %0d want src 1 set 2", pc_src, pc_set); end
        tick();
        checks++; if (replay_cnt !== 16'd1) begin errors++; $display("[TB] FAIL bp_replay_cnt got %0d want 1", replay_cnt); end
        checks++; if (id_pc !== 32'd0 || id_instr !== 32'd100) begin errors++; $display("[TB] FAIL bp_stable got pc %0d instr %0d want pc 0 instr 100", id_pc, id_instr); end
        checks++; if (pc_src !== 1'b0) begin errors++; $display("[TB] FAIL bp_stale_req got %0b want 0", pc_src); end
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_pc.size() <= i) begin
                errors++; $display("[TB] FAIL bp_order[%0d] got none want pc %0d", i, i);
            end else if (log_pc[i] !== 32'(i) || log_instr[i] !== 32'(i + 100)) begin
                errors++; $display("[TB] FAIL bp_order[%0d] got pc %0d instr %0d want pc %0d instr %0d", i, log_pc[i], log_instr[i], i, i + 100);
            end
        end
        checks++; if (replay_cnt !== 16'd1) begin errors++; $display("[TB] FAIL bp_replay_cnt_end got %0d want 1", replay_cnt); end
    endtask

    task automatic test_flush();
        int n;
        apply_reset();
        id_ready = 1'b0;
        tick();
        tick();
        tick();
        flush_target = 32'h40;
        flush        = 1'b1;
        #1;
        checks++; if (pc_src !== 1'b1 || pc_set !== 32'h40) begin errors++; $display("[TB] FAIL flush_redirect got src %0b set %0h want src 1 set 40", pc_src, pc_set); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got %0b want 0", id_valid); end
        checks++; if (replay_cnt !== 16'd0) begin errors++; $display("[TB] FAIL flush_replay_cnt got %0d want 0", replay_cnt); end
        checks++; if (pc_in !== 32'h40) begin errors++; $display("[TB] FAIL flush_pc_loaded got %0h want 40", pc_in); end
        id_ready = 1'b1;
        n = 0;
        while (!id_valid && n < 6) begin
            tick();
            n++;
        end
        checks++; if (n != 2) begin errors++; $display("[TB] FAIL flush_refill_latency got %0d want 2", n); end
        checks++; if (id_pc !== 32'h40 || id_instr !== 32'd164) begin errors++; $display("[TB] FAIL flush_next got pc %0h instr %0d want pc 40 instr 164", id_pc, id_instr); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        id_ready = 1'b0;
        tick();
        tick();
        tick();
        id_ready = 1'b1;
        #1;
        checks++; if (pc_src !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_replay got %0b want 0", pc_src); end
        tick();
        id_ready = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'd1 || id_instr !== 32'd101) begin errors++; $display("[TB] FAIL b2b_head got v %0b pc %0d instr %0d want v 1 pc 1 instr 101", id_valid, id_pc, id_instr); end
        checks++; if (pc_src !== 1'b1 || pc_set !== 32'd3) begin errors++; $display("[TB] FAIL b2b_still_full got src %0b set %0d want src 1 set 3", pc_src, pc_set); end
        checks++; if (replay_cnt !== 16'd0) begin errors++; $display("[TB] FAIL b2b_replay_cnt got %0d want 0", replay_cnt); end
    endtask

    task automatic test_reset_full();
        apply_reset();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (replay_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rf_pre_cnt got %0d want 1", replay_cnt); end
        reset = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_id_valid got %0b want 0", id_valid); end
        checks++; if (replay_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rf_replay_cnt got %0d want 0", replay_cnt); end
        checks++; if (pc_src !== 1'b0 || pc_set !== 32'h0) begin errors++; $display("[TB] FAIL rf_redirect got src %0b set %0h want src 0 set 0", pc_src, pc_set); end
        reset    = 1'b1;
        id_ready = 1'b1;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL rf_first_cycle got %0b want 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== RST_PC || id_instr !== 32'd100) begin errors++; $display("[TB] FAIL rf_restart got v %0b pc %0h instr %0d want v 1 pc %0h instr 100", id_valid, id_pc, id_instr, RST_PC); end
    endtask

    initial begin
        pc_in        = RST_PC;
        imem_rdata   = 32'h0;
        reset        = 1'b0;
        flush        = 1'b0;
        flush_target = 32'h0;
        id_ready     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
